// File: rtl/pwm_width_sched.sv
// Wishbone width scheduler feeding the 4-channel PWM generator.
// Optional register readback via `define PWM_WS_READBACK_EN.
module pwm_width_sched #(
    parameter int          PRESCALE   = 16,
    parameter logic [15:0] FS_DEFAULT = 16'd0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [6:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic [15:0] width1,
    output logic [15:0] width2,
    output logic [15:0] width3,
    output logic [15:0] width4,
    output logic        frame_tick,
    output logic        failsafe
);

    localparam logic [2:0] ST_DISARMED = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_PENDING  = 3'd2;
    localparam logic [2:0] ST_FAILSAFE = 3'd3;

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [2:0]  state;
    logic        arm;
    logic [15:0] frame_len;
    logic [15:0] wdog_len;
    logic [15:0] shadow [4];
    logic [15:0] fs_w   [4];
    logic [15:0] w      [4];
    logic [15:0] pre;
    logic [15:0] fcnt;
    logic [15:0] wd;

    logic [4:0]  a;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_fl;
    logic        commit_req;
    logic        arm_nx;
    logic        tick_now;
    logic [15:0] wd_nx;
    logic        expire;
    logic        unused_adr;

    assign a          = wb_adr_i[4:0];
    assign unused_adr = ^wb_adr_i[6:5];
    assign wr         = wb_cyc_i & wb_stb_i & wb_we_i & wb_ack_o;
    assign wr_ctrl    = wr && (a == 5'h00);
    assign wr_fl      = wr && (a == 5'h04);
    assign commit_req = wr_ctrl && wb_dat_i[1];
    assign arm_nx     = wr_ctrl ? wb_dat_i[0] : arm;

    assign width1 = w[0];
    assign width2 = w[1];
    assign width3 = w[2];
    assign width4 = w[3];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
        end else begin
            wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o;
        end
    end

    // Writes land on the ack cycle; odd addresses fall through as unmapped.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            arm       <= 1'b0;
            frame_len <= 16'd0;
            wdog_len  <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 16'd0;
                fs_w[i]   <= FS_DEFAULT;
            end
        end else if (wr) begin
            if (a == 5'h00) arm <= wb_dat_i[0];
            if (a == 5'h04) frame_len <= wb_dat_i;
            if (a == 5'h06) wdog_len <= wb_dat_i;
            if (a[4:3] == 2'b10 && !a[0]) shadow[a[2:1]] <= wb_dat_i;
            if (a[4:3] == 2'b11 && !a[0]) fs_w[a[2:1]] <= wb_dat_i;
        end
    end

    assign tick_now = !wr_fl && (frame_len != 16'd0) &&
                      (pre == PRE_MAX) && (fcnt == frame_len - 16'd1);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pre        <= 16'd0;
            fcnt       <= 16'd0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= tick_now;
            if (wr_fl) begin
                pre  <= 16'd0;
                fcnt <= 16'd0;
            end else if (frame_len != 16'd0) begin
                if (pre == PRE_MAX) begin
                    pre  <= 16'd0;
                    fcnt <= (fcnt == frame_len - 16'd1) ? 16'd0 : fcnt + 16'd1;
                end else begin
                    pre <= pre + 16'd1;
                end
            end
        end
    end

    assign wd_nx  = (tick_now && wd != 16'hFFFF) ? wd + 16'd1 : wd;
    assign expire = (wdog_len != 16'd0) && (wd_nx == wdog_len);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= ST_DISARMED;
            failsafe <= 1'b0;
            wd       <= 16'd0;
            for (int i = 0; i < 4; i++) w[i] <= 16'd0;
        end else if (!arm_nx) begin
            state    <= ST_DISARMED;
            failsafe <= 1'b0;
            wd       <= 16'd0;
            for (int i = 0; i < 4; i++) w[i] <= 16'd0;
        end else begin
            case (state)
                ST_DISARMED: state <= ST_IDLE;
                ST_IDLE: begin
                    wd <= wd_nx;
                    if (commit_req) begin
                        state <= ST_PENDING;
                    end else if (expire) begin
                        state    <= ST_FAILSAFE;
                        failsafe <= 1'b1;
                        for (int i = 0; i < 4; i++) w[i] <= fs_w[i];
                    end
                end
                ST_PENDING: begin
                    // A commit written on this very tick still sees IDLE/FAILSAFE.
                    if (tick_now) begin
                        state    <= ST_IDLE;
                        failsafe <= 1'b0;
                        wd       <= 16'd0;
                        for (int i = 0; i < 4; i++) w[i] <= shadow[i];
                    end else begin
                        wd <= wd_nx;
                    end
                end
                ST_FAILSAFE: begin
                    for (int i = 0; i < 4; i++) w[i] <= fs_w[i];
                    if (commit_req) state <= ST_PENDING;
                end
                default: state <= ST_DISARMED;
            endcase
        end
    end

`ifdef PWM_WS_READBACK_EN
    logic [15:0] rd;

    always_comb begin
        rd = 16'd0;
        case (a)
            5'h00: rd = {15'd0, arm};
            5'h02: rd = {10'd0, state, failsafe, state == ST_PENDING, arm};
            5'h04: rd = frame_len;
            5'h06: rd = wdog_len;
            5'h10, 5'h12, 5'h14, 5'h16: rd = shadow[a[2:1]];
            5'h18, 5'h1A, 5'h1C, 5'h1E: rd = fs_w[a[2:1]];
            default: rd = 16'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_dat_o <= 16'd0;
        end else if (wb_cyc_i & wb_stb_i & ~wb_ack_o) begin
            wb_dat_o <= rd;
        end
    end
`else
    assign wb_dat_o = 16'd0;
`endif

endmodule

// File: tb/tb_pwm_width_sched.sv
// Directed bench for pwm_width_sched (PRESCALE=16).
// STATUS readback checks are built only with PWM_WS_READBACK_EN.
module tb_pwm_width_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [6:0]  adr = 7'd0;
    logic [15:0] dat = 16'd0;
    logic [15:0] dat_o;
    logic        ack;
    logic [15:0] w1, w2, w3, w4;
    logic        ftick;
    logic        fsafe;

    int total = 0;
    int bad   = 0;
    int n;
    int cnt;

    pwm_width_sched #(.PRESCALE(16), .FS_DEFAULT(16'd0)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat),
        .wb_dat_o  (dat_o),
        .wb_ack_o  (ack),
        .width1    (w1),
        .width2    (w2),
        .width3    (w3),
        .width4    (w4),
        .frame_tick(ftick),
        .failsafe  (fsafe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the write edge.
    task automatic wr(input logic [6:0] a, input logic [15:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d;
        @(posedge clk);
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

`ifdef PWM_WS_READBACK_EN
    task automatic rd(input logic [6:0] a, output logic [15:0] d);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        @(posedge clk);
        #1;
        d = dat_o;
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
    endtask
    logic [15:0] rv;
`endif

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!ftick && cycles < 400);
        if (!ftick) begin
            total++;
            bad++;
            $error("FAIL tick_timeout: got 0 want 1");
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w1", w1, 0);
        chk("rst_fs", fsafe, 0);
        rst = 1'b0;
        chk("rst_w4", w4, 0);

        cnt = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (ftick) cnt++;
        end
        chk("no_tick_len0", cnt, 0);

        cyc = 1'b1; stb = 1'b1; adr = 7'h08;
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ack) cnt++;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("ack_held", cnt, 4);
        @(posedge clk);
        #1;
        chk("ack_drop", ack, 0);

`ifdef PWM_WS_READBACK_EN
        rd(7'h02, rv);
        chk("status_rst", rv, 0);
`endif

        wr(7'h04, 16'd10);
        wait_tick(n);
        wait_tick(n);
        chk("period", n, 160);
        @(posedge clk);
        #1;
        chk("tick_width", ftick, 0);

        wr(7'h00, 16'h0001);
        wr(7'h06, 16'd3);
        wr(7'h18, 16'd1000);
        wr(7'h10, 16'd100);
        wr(7'h12, 16'd200);
        wr(7'h14, 16'd300);
        wr(7'h16, 16'd400);
        wr(7'h00, 16'h0003);
        chk("pre_commit_w1", w1, 0);
`ifdef PWM_WS_READBACK_EN
        rd(7'h02, rv);
        chk("status_pend", rv, 16'h0013);
`endif
        wait_tick(n);
        chk("commit_w1", w1, 100);
        chk("commit_w2", w2, 200);
        chk("commit_w3", w3, 300);
        chk("commit_w4", w4, 400);
        chk("commit_fs", fsafe, 0);
`ifdef PWM_WS_READBACK_EN
        rd(7'h02, rv);
        chk("status_idle", rv, 16'h0009);
`endif

        wait_tick(n);
        chk("wd_tick1_fs", fsafe, 0);
        wait_tick(n);
        chk("wd_tick2_fs", fsafe, 0);
        wait_tick(n);
        chk("wd_tick3_fs", fsafe, 1);
        chk("wd_tick3_w1", w1, 1000);
        chk("wd_tick3_w2", w2, 0);

        wr(7'h18, 16'd1500);
        @(posedge clk);
        #1;
        chk("fs_track_w1", w1, 1500);

        wr(7'h10, 16'd222);
        wr(7'h00, 16'h0003);
        chk("fs_pend_fs", fsafe, 1);
        wait_tick(n);
        chk("fs_exit_fs", fsafe, 0);
        chk("fs_exit_w1", w1, 222);
        chk("fs_exit_w2", w2, 200);

        wr(7'h06, 16'd0);
        wr(7'h10, 16'd333);
        wait_tick(n);
        repeat (158) @(posedge clk);
        #1;
        wr(7'h00, 16'h0003);
        chk("cot_align", ftick, 1);
        chk("cot_w1", w1, 222);
        repeat (158) @(posedge clk);
        #1;
        wr(7'h10, 16'd444);
        chk("shw_align", ftick, 1);
        chk("shw_old_w1", w1, 333);
        wr(7'h00, 16'h0003);
        wait_tick(n);
        chk("shw_new_w1", w1, 444);

        wr(7'h00, 16'h0003);
        wr(7'h00, 16'h0000);
        chk("disarm_w1", w1, 0);
        chk("disarm_w4", w4, 0);
`ifdef PWM_WS_READBACK_EN
        rd(7'h02, rv);
        chk("status_disarm", rv, 0);
`endif
        wait_tick(n);
        chk("disarm_tick_w1", w1, 0);

        wr(7'h00, 16'h0001);
        wr(7'h00, 16'h0003);
        wait_tick(n);
        chk("rearm_w1", w1, 444);
        chk("rearm_w2", w2, 200);
        repeat (40) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_w1", w1, 0);
        chk("async_rst_w2", w2, 0);
        chk("async_rst_fs", fsafe, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (ftick) cnt++;
        end
        chk("post_rst_ticks", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_width_sched.md
Name: pwm_width_sched

Overview:
Wishbone-attached width scheduler. It sits directly upstream of the 4-channel PWM generator and drives that generator's width inputs. Software writes shadow widths, which are committed atomically to the active widths on a frame boundary. A watchdog counts frames without a commit and forces programmed failsafe widths when it expires. The block is the only source of PWM widths; the generator consumes width1..width4 unmodified.

Parameters:
PRESCALE, 16, wb_clk_i cycles per frame-counter tick; legal range 1..65535.
FS_DEFAULT, 16'd0, reset value of all four failsafe width registers.

Ports:
wb_clk_i  in  1  Wishbone/system clock
wb_rst_i  in  1  reset, asynchronous, active-high
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  7  byte address; only [4:0] decoded
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data
wb_ack_o  out  1  registered acknowledge
width1..width4  out  16 each  active widths to PWM generator
frame_tick  out  1  one-cycle pulse at each frame boundary
failsafe  out  1  high while failsafe widths are active

Behaviour:
- Reset values: all outputs 0. Shadow widths 0, failsafe widths FS_DEFAULT, FRAME_LEN 0, WDOG_LEN 0. State DISARMED.
- Register map (adr[4:0]):
  - 0x00 CTRL: bit0 ARM (rw); bit1 COMMIT (write 1 = request, reads 0).
  - 0x02 STATUS (ro): bit0 armed, bit1 pending, bit2 failsafe, bits[5:3] state encoding.
  - 0x04 FRAME_LEN.
  - 0x06 WDOG_LEN.
  - 0x10/12/14/16: shadow width ch1..4.
  - 0x18/1A/1C/1E: failsafe width ch1..4.
  - Unmapped addresses: writes ignored, reads 0, still acked.
- Wishbone: ack rises the cycle after cyc&stb is sampled with ack low, and stays high exactly 1 cycle. A held request yields one ack every 2 cycles. Write is applied on the ack cycle.
- Frame timer: prescaler counts 0..PRESCALE-1. On each prescaler wrap, frame counter counts 0..FRAME_LEN-1. frame_tick pulses on the cycle the frame counter wraps to 0. FRAME_LEN=0 stops both counters (no ticks). Writing FRAME_LEN clears both counters.
- FSM states:
  - DISARMED: widths forced 0, failsafe=0, pending cleared, watchdog cleared. ARM=1 -> IDLE.
  - IDLE: widths hold last committed values. COMMIT write -> PENDING. Watchdog expiry -> FAILSAFE.
  - PENDING: on the next frame_tick, widthN <= shadowN for all 4 channels in the same cycle. Then pending=0, watchdog=0, -> IDLE.
  - FAILSAFE: widthN <= failsafeN on entry and tracks failsafe register writes; failsafe=1. COMMIT write -> PENDING; failsafe clears at the commit tick.
  - ARM=0 from any state -> DISARMED on the next cycle.
- Watchdog: 16-bit counter, increments per frame_tick in IDLE/PENDING, saturates. Expires when count == WDOG_LEN and WDOG_LEN != 0. WDOG_LEN=0 disables the watchdog.
- Simultaneous events:
  - COMMIT write in the same cycle as frame_tick: the commit is not applied at that tick; it waits for the next one.
  - Shadow write in the same cycle as a commit tick: the commit uses the old shadow value; the new value is retained for the next commit.
  - Watchdog expiry at the same tick as a pending commit: the commit wins and the watchdog clears.
  - A second COMMIT while PENDING has no additional effect.
- Reset mid-operation: all state returns to reset values immediately. widthN=0 asynchronously.

Optional Feature:
PWM_WS_READBACK_EN: defined -> wb_dat_o returns the register contents per the map, registered and valid with ack. Undefined -> wb_dat_o is constant 0 and read logic is omitted. Writes and ack timing are identical in both builds.

Test Plan:
- Reset -> width1..4=0, failsafe=0, STATUS=0, frame_tick never pulses with FRAME_LEN=0.
- PRESCALE=16, FRAME_LEN=10 -> frame_tick period exactly 160 wb_clk_i cycles, 1 cycle wide.
- ARM, shadow ch1..4=100/200/300/400, COMMIT -> widths unchanged until the next frame_tick, then all four update in the same cycle. STATUS pending 1 -> 0.
- WDOG_LEN=3, failsafe ch1=1000, no commits -> on the 3rd frame_tick width1=1000, failsafe=1. COMMIT -> failsafe=0 at the following tick, width1=shadow1.
- COMMIT written on the frame_tick cycle -> applied one full frame later. Shadow write on the commit tick -> old value committed.
- Clear ARM while PENDING -> widths 0 next cycle, pending=0. Assert wb_rst_i mid-frame -> all outputs 0 asynchronously.
